// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that assembles a little-endian byte stream
// into 32-bit words, writes them to imem at consecutive word addresses, and
// holds the CPU in reset until the whole image is in place.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte (CHK state) that must match before the CPU is released.
//
// Handshake: a byte moves on a rising edge where in_valid=1 and in_ready=1;
// in_ready is a function of state only and never looks at in_valid, and
// in_valid/in_data are ignored whenever in_ready=0.
module imem_loader #(
   parameter int IMEM_DEPTH      = 1024,
   parameter int IMEM_ADDR_WIDTH = 10
) (
   input  logic                       clk,
   input  logic                       reset_b,
   input  logic                       in_valid,
   input  logic [7:0]                 in_data,
   output logic                       in_ready,
   input  logic                       reload,
   output logic                       wr_en,
   output logic [IMEM_ADDR_WIDTH-1:0] wr_addr,
   output logic [31:0]                wr_data,
   output logic                       cpu_reset_b,
   output logic                       busy,
   output logic                       done,
   output logic                       err,
   output logic [2:0]                 dbg_state
);

   typedef enum logic [2:0] {
      S_HDR_LO = 3'd0,
      S_HDR_HI = 3'd1,
      S_DATA   = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK    = 3'd3,
`endif
      S_DONE   = 3'd4,
      S_ERR    = 3'd5
   } state_t;

   // Where the stream goes once the last data word (or an empty image) is in.
   localparam state_t S_AFTER_DATA =
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK;
`else
      S_DONE;
`endif

   state_t      state;
   state_t      state_d;
   logic        accept;
   logic [15:0] n_words;
   logic [15:0] hdr_n;
   logic [15:0] word_idx;
   logic [1:0]  byte_cnt;
   logic [23:0] shift;
   logic        last_word;
   logic        restart;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  csum;
`endif

   assign accept    = in_valid & in_ready;
   assign hdr_n     = {in_data, n_words[7:0]};
   assign last_word = (word_idx == (n_words - 16'd1));
   assign restart   = ((state == S_DONE) || (state == S_ERR)) && reload;
   assign dbg_state = state;

   // Status outputs decoded from the current state only.
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      err      = 1'b0;
      case (state)
         S_DONE:  done = 1'b1;
         S_ERR:   err  = 1'b1;
         default: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
      endcase
   end

   // Next-state logic.
   always_comb begin
      state_d = state;
      case (state)
         S_HDR_LO: if (accept) state_d = S_HDR_HI;
         S_HDR_HI: begin
            if (accept) begin
               if ({1'b0, hdr_n} > 17'(IMEM_DEPTH)) state_d = S_ERR;
               else if (hdr_n == 16'd0)             state_d = S_AFTER_DATA;
               else                                 state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (accept && (byte_cnt == 2'd3) && last_word) state_d = S_AFTER_DATA;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHK: begin
            if (accept) state_d = (in_data == csum) ? S_DONE : S_ERR;
         end
`endif
         S_DONE, S_ERR: if (reload) state_d = S_HDR_LO;
         default: state_d = S_HDR_LO;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) state <= S_HDR_LO;
      else          state <= state_d;
   end

   // CPU release: high only while DONE persists, so it rises one edge after
   // DONE is entered and drops on the very edge that reload leaves DONE.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) cpu_reset_b <= 1'b0;
      else          cpu_reset_b <= (state == S_DONE) && (state_d == S_DONE);
   end

   // Header capture, word assembly and the imem write port.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         n_words  <= '0;
         word_idx <= '0;
         byte_cnt <= '0;
         shift    <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
      end else begin
         wr_en <= 1'b0;
         if (restart) begin
            word_idx <= '0;
            byte_cnt <= '0;
         end else if (accept) begin
            case (state)
               S_HDR_LO: n_words[7:0]  <= in_data;
               S_HDR_HI: n_words[15:8] <= in_data;
               S_DATA: begin
                  byte_cnt <= byte_cnt + 2'd1;
                  shift    <= {in_data, shift[23:8]};
                  if (byte_cnt == 2'd3) begin
                     wr_en    <= 1'b1;
                     wr_addr  <= word_idx[IMEM_ADDR_WIDTH-1:0];
                     wr_data  <= {in_data, shift};
                     word_idx <= word_idx + 16'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   // Running XOR over data bytes only; restarted with every new load.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b)                         csum <= 8'h00;
      else if (restart)                     csum <= 8'h00;
      else if (accept && (state == S_DATA)) csum <= csum ^ in_data;
   end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; works with or without IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

   localparam int AW = 10;
   localparam int W  = AW + 32;

   logic          clk = 1'b0;
   logic          reset_b;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          reload;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [31:0]   wr_data;
   logic          cpu_reset_b;
   logic          busy;
   logic          done;
   logic          err;
   logic [2:0]    dbg_state;

   int n_checks = 0;
   int n_fails  = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] got_q[$];

   imem_loader #(.IMEM_DEPTH(1024), .IMEM_ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset_b(reset_b), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .reload(reload), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .cpu_reset_b(cpu_reset_b), .busy(busy), .done(done),
      .err(err), .dbg_state(dbg_state)
   );

   // Clock / reset
   always #5 clk = ~clk;

   // Write monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (wr_en === 1'b1) got_q.push_back({wr_addr, wr_data});
   end

   // ---------------- driver tasks ----------------
   task automatic send_bytes(input logic [7:0] b[$], input bit toggle);
      foreach (b[i]) begin
         int n;
         n = 0;
         in_valid = 1'b1;
         in_data  = b[i];
         while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
         end
         if (in_ready !== 1'b1) begin
            n_checks++; n_fails++;
            $display("FAIL send_timeout: in_ready=%b required 1 (byte %0d)", in_ready, i);
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
         if (toggle && i != b.size() - 1) begin
            in_data = 8'hFF;
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic send_basic(input bit toggle);
      logic [7:0] s[$];
      s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
      s.push_back(8'hB0);
`endif
      send_bytes(s, toggle);
   endtask

   task automatic do_reload();
      reload = 1'b1;
      @(posedge clk); #1;
      reload = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset_b = 1'b0; in_valid = 1'b0; in_data = 8'h00; reload = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({in_ready, busy, wr_en, cpu_reset_b, done, err} !== 6'b110000) begin
         n_fails++;
         $display("FAIL reset_flags: rdy/busy/wen/cpu/done/err=%b required 110000",
                  {in_ready, busy, wr_en, cpu_reset_b, done, err});
      end
      n_checks++;
      if (wr_addr !== '0 || wr_data !== 32'h0) begin
         n_fails++;
         $display("FAIL reset_wr: addr=%h data=%h required 0/0", wr_addr, wr_data);
      end
      n_checks++;
      if (dbg_state !== 3'd0) begin
         n_fails++;
         $display("FAIL reset_state: state=%0d required 0", dbg_state);
      end
      @(negedge clk) reset_b = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic [W-1:0] e, g;
      got_q.delete(); exp_q.delete();
      exp_q.push_back({10'd0, 32'h00100513});
      exp_q.push_back({10'd1, 32'h00200593});
      send_basic(1'b0);
      n_checks++;
      if (done !== 1'b1 || cpu_reset_b !== 1'b0) begin
         n_fails++;
         $display("FAIL basic_done_edge: done=%b cpu=%b required 1/0", done, cpu_reset_b);
      end
      @(posedge clk); #1;
      n_checks++;
      if (cpu_reset_b !== 1'b1 || done !== 1'b1) begin
         n_fails++;
         $display("FAIL basic_release: cpu=%b done=%b required 1/1", cpu_reset_b, done);
      end
      n_checks++;
      if (got_q.size() !== exp_q.size()) begin
         n_fails++;
         $display("FAIL basic_nwrites: got %0d required %0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front();
         n_checks++;
         if (g !== e) begin
            n_fails++;
            $display("FAIL basic_write: got addr=%h data=%h required addr=%h data=%h",
                     g[W-1:32], g[31:0], e[W-1:32], e[31:0]);
         end
      end
   endtask

   task automatic test_reload();
      logic [7:0] s[$];
      logic [W-1:0] e, g;
      do_reload();
      n_checks++;
      if (cpu_reset_b !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
         n_fails++;
         $display("FAIL reload_exit: cpu=%b done=%b rdy=%b required 0/0/1",
                  cpu_reset_b, done, in_ready);
      end
      got_q.delete(); exp_q.delete();
      exp_q.push_back({10'd0, 32'hDEADBEEF});
      s = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef IMEM_LOADER_CHECKSUM_EN
      s.push_back(8'h22);
`endif
      send_bytes(s, 1'b0);
      @(posedge clk); #1;
      n_checks++;
      if (cpu_reset_b !== 1'b1 || done !== 1'b1) begin
         n_fails++;
         $display("FAIL reload_release: cpu=%b done=%b required 1/1", cpu_reset_b, done);
      end
      n_checks++;
      if (got_q.size() !== exp_q.size()) begin
         n_fails++;
         $display("FAIL reload_nwrites: got %0d required %0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front();
         n_checks++;
         if (g !== e) begin
            n_fails++;
            $display("FAIL reload_write: got addr=%h data=%h required addr=%h data=%h",
                     g[W-1:32], g[31:0], e[W-1:32], e[31:0]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] e, g;
      do_reload();
      got_q.delete(); exp_q.delete();
      exp_q.push_back({10'd0, 32'h00100513});
      exp_q.push_back({10'd1, 32'h00200593});
      send_basic(1'b1);
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (cpu_reset_b !== 1'b1 || done !== 1'b1) begin
         n_fails++;
         $display("FAIL bp_release: cpu=%b done=%b required 1/1", cpu_reset_b, done);
      end
      n_checks++;
      if (got_q.size() !== exp_q.size()) begin
         n_fails++;
         $display("FAIL bp_nwrites: got %0d required %0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front();
         n_checks++;
         if (g !== e) begin
            n_fails++;
            $display("FAIL bp_write: got addr=%h data=%h required addr=%h data=%h",
                     g[W-1:32], g[31:0], e[W-1:32], e[31:0]);
         end
      end
   endtask

   task automatic test_oversize();
      logic [7:0] s[$];
      do_reload();
      got_q.delete();
      s = '{8'h01, 8'h04};
      send_bytes(s, 1'b0);
      n_checks++;
      if (err !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
         n_fails++;
         $display("FAIL oversize_err: err=%b rdy=%b busy=%b required 1/0/0", err, in_ready, busy);
      end
      // Bytes offered while in ERR must be ignored.
      in_valid = 1'b1; in_data = 8'h55;
      repeat (3) @(posedge clk);
      #1;
      in_valid = 1'b0;
      n_checks++;
      if (cpu_reset_b !== 1'b0 || err !== 1'b1 || got_q.size() != 0) begin
         n_fails++;
         $display("FAIL oversize_hold: cpu=%b err=%b writes=%0d required 0/1/0",
                  cpu_reset_b, err, got_q.size());
      end
   endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
   task automatic test_bad_checksum();
      logic [7:0] s[$];
      do_reload();
      got_q.delete();
      s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hB1};
      send_bytes(s, 1'b0);
      @(posedge clk); #1;
      n_checks++;
      if (err !== 1'b1 || cpu_reset_b !== 1'b0 || done !== 1'b0) begin
         n_fails++;
         $display("FAIL badchk_err: err=%b cpu=%b done=%b required 1/0/0", err, cpu_reset_b, done);
      end
      n_checks++;
      if (got_q.size() != 2) begin
         n_fails++;
         $display("FAIL badchk_nwrites: got %0d required 2", got_q.size());
      end
      do_reload();
      n_checks++;
      if (in_ready !== 1'b1 || err !== 1'b0) begin
         n_fails++;
         $display("FAIL badchk_reload: rdy=%b err=%b required 1/0", in_ready, err);
      end
      send_basic(1'b0);
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b1 || cpu_reset_b !== 1'b1) begin
         n_fails++;
         $display("FAIL badchk_recover: done=%b cpu=%b required 1/1", done, cpu_reset_b);
      end
   endtask
`endif

   task automatic test_reset_mid();
      logic [7:0] s[$];
      logic [W-1:0] e, g;
      do_reload();
      got_q.delete(); exp_q.delete();
      s = '{8'h02, 8'h00, 8'h13, 8'h05};
      send_bytes(s, 1'b0);
      reset_b = 1'b0;
      #2;
      n_checks++;
      if ({in_ready, busy, wr_en, cpu_reset_b, done, err} !== 6'b110000 ||
          wr_addr !== '0 || wr_data !== 32'h0) begin
         n_fails++;
         $display("FAIL midreset_outputs: flags=%b addr=%h data=%h required 110000/0/0",
                  {in_ready, busy, wr_en, cpu_reset_b, done, err}, wr_addr, wr_data);
      end
      @(negedge clk) reset_b = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (got_q.size() != 0) begin
         n_fails++;
         $display("FAIL midreset_nowrite: got %0d writes required 0", got_q.size());
      end
      exp_q.push_back({10'd0, 32'h00100513});
      exp_q.push_back({10'd1, 32'h00200593});
      send_basic(1'b0);
      @(posedge clk); #1;
      n_checks++;
      if (got_q.size() !== exp_q.size() || cpu_reset_b !== 1'b1) begin
         n_fails++;
         $display("FAIL midreset_reload: writes=%0d cpu=%b required %0d/1",
                  got_q.size(), cpu_reset_b, exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front();
         n_checks++;
         if (g !== e) begin
            n_fails++;
            $display("FAIL midreset_write: got addr=%h data=%h required addr=%h data=%h",
                     g[W-1:32], g[31:0], e[W-1:32], e[31:0]);
         end
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_basic();
      test_reload();
      test_backpressure();
      test_oversize();
`ifdef IMEM_LOADER_CHECKSUM_EN
      test_bad_checksum();
`endif
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction loader that sits directly upstream of the single-cycle CPU's instruction memory. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Each word is written into the imem write port at consecutive word addresses. The CPU is held in reset until the whole image has been written, and is released only then.

## Interface
- IMEM_DEPTH, 1024: number of imem words; maximum legal image length.
- IMEM_ADDR_WIDTH, 10: imem word-address width; must be ≤16.
- clk  input  1  system clock; all state changes on its rising edge.
- reset_b  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data carries a byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte; depends on state only, never on in_valid.
- reload  input  1  single-cycle request to start a new load; honoured only in DONE or ERR.
- wr_en  output  1  imem write strobe, one cycle per word.
- wr_addr  output  IMEM_ADDR_WIDTH  imem word address.
- wr_data  output  32  imem write word.
- cpu_reset_b  output  1  active-low reset to the CPU; registered.
- busy  output  1  a load is in progress.
- done  output  1  image loaded, CPU released.
- err  output  1  load aborted; CPU held in reset.

## Operation
- Byte transfer: a byte is accepted on a rising edge where in_valid=1 and in_ready=1. At most one byte is accepted per cycle.
- Stream format:
  - N_lo, N_hi: 16-bit little-endian word count N.
  - 4·N data bytes, each word least-significant byte first.
  - Optional checksum byte (see Configuration).
- States:
  - HDR_LO: accept N_lo, then go to HDR_HI.
  - HDR_HI: accept N_hi. If N > IMEM_DEPTH, go to ERR. If N = 0, go to CHK when checksum is compiled in, otherwise DONE. Otherwise go to DATA.
  - DATA: byte counter 0..3 fills a word shift register.
    - On the 4th byte: register wr_en=1, wr_addr=word index, wr_data={b3,b2,b1,b0}, then increment the word index.
    - After word N−1: go to CHK when checksum is compiled in, otherwise DONE.
  - CHK: accept one byte. Equal to the running checksum: go to DONE. Otherwise: go to ERR.
  - DONE / ERR: hold state. reload=1 returns to HDR_LO and clears the word index, byte counter and checksum.
- Outputs from state:
  - in_ready=1 in HDR_LO, HDR_HI, DATA, CHK; 0 in DONE and ERR.
  - busy=1 in HDR_LO..CHK.
  - done=1 in DONE; err=1 in ERR.
- Arithmetic and counters:
  - Word index is 16 bits; wr_addr is its low IMEM_ADDR_WIDTH bits.
  - The N > IMEM_DEPTH check makes address wrap impossible.
- Ignored inputs:
  - reload is ignored while busy.
  - in_valid in DONE or ERR has no effect.
- Reset mid-operation: any partial word is discarded, no write is issued, and the next load starts at address 0.

## Timing
- Reset values:
  - state HDR_LO; in_ready=1, busy=1.
  - wr_en=0, wr_addr=0, wr_data=0.
  - cpu_reset_b=0, done=0, err=0.
- Write latency: wr_en is high for exactly the one cycle after the edge that accepts a word's 4th byte.
  - wr_addr and wr_data are valid in that cycle and hold until the next write.
- Release latency: cpu_reset_b rises on the edge after the edge that enters DONE.
  - It therefore rises one cycle after the final wr_en cycle (no checksum), or one cycle after the checksum byte is accepted.
- cpu_reset_b falls on the same edge at which reload takes the loader out of DONE.
- cpu_reset_b is never 1 outside DONE.
- Throughput: one byte per cycle with in_valid held high; gaps in in_valid stall the loader with no loss or duplication.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - The CHK state exists.
  - The running checksum is the XOR of all data bytes (header excluded), reset to 0x00 at each load start.
  - N=0 expects a checksum byte of 0x00.
  - Words are written to imem before validation; a mismatch leaves the CPU in reset with err=1.
- IMEM_LOADER_CHECKSUM_EN undefined: no CHK state and no checksum logic; the stream ends after the last data byte.

## Test plan
- Basic load, continuous stream 02 00 13 05 10 00 93 05 20 00 (plus B0 when checksum is enabled):
  - wr addr0=0x00100513, addr1=0x00200593.
  - cpu_reset_b=1 and done=1 one cycle after the last write (no checksum) or after the checksum byte is accepted (checksum enabled).
- Backpressure: same stream with in_valid toggling every cycle -> identical two writes, no extra wr_en pulses.
- Oversize header 01 04 (N=1025, IMEM_DEPTH=1024) -> err=1, in_ready=0, no wr_en, cpu_reset_b stays 0.
- Checksum enabled, basic stream with final byte B1 -> both words written, err=1, cpu_reset_b=0. Then reload -> in_ready=1, err=0, and a good stream reaches done.
- reset_b pulsed low after two data bytes -> all outputs return to reset values. A subsequent full basic stream writes addr0 and addr1 correctly.
- reload in DONE -> cpu_reset_b=0 on the next edge. A new stream 01 00 EF BE AD DE (plus 22 when checksum is enabled) writes addr0=0xDEADBEEF, then the CPU is released.
